// File: rtl/burst_arbiter_mux_if.sv
// burst_arbiter_mux_if
// Bundles the N requester streams, the shared downstream stream and the
// arbiter status outputs into one port.
//   in_valid/in_last/in_data  requester beats (in_data: requester i at [i*W +: W])
//   in_ready                  per-requester ready, at most one bit high
//   out_valid/out_last/out_data/out_ready  shared downstream channel
//   out_sel                   index of the granted requester
//   busy                      high while a burst is locked
// Modports:
//   slave   the arbiter's view
//   master  the surrounding environment's view
interface burst_arbiter_mux_if #(
  parameter int N = 2,
  parameter int W = 64
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic             out_last;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;
  logic             busy;

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel, busy
  );

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel, busy
  );
endinterface

// File: rtl/burst_arbiter_mux.sv
// burst_arbiter_mux
// Round-robin arbiter/multiplexer sharing one valid/ready stream between N
// requesters. A grant is taken per burst and held until the granted
// requester's last beat is accepted, so bursts never interleave. The next
// search starts just after the most recently granted requester.
// Ports:
//   clk   clock, all state on the rising edge
//   rstn  asynchronous active-low reset
//   bus   burst_arbiter_mux_if.slave (requester inputs, shared output,
//         out_sel, busy)
module burst_arbiter_mux #(
  parameter int N = 2,
  parameter int W = 64
) (
  input logic                clk,
  input logic                rstn,
  burst_arbiter_mux_if.slave bus
);
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] LSB = N'(1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     grant_reg, grant_next;
  logic [N-1:0]     ptr_reg, ptr_next;
  logic [SEL_W-1:0] sel_reg, sel_next;

  logic [N-1:0]     higher_mask;
  logic [N-1:0]     req_hi;
  logic [N-1:0]     req_src;
  logic [N-1:0]     pick;
  logic [SEL_W-1:0] pick_idx;

  logic [W-1:0]     data_masked [N];
  logic [W-1:0]     data_or;

  logic             out_valid_c;
  logic             out_last_c;
  logic [W-1:0]     out_data_c;
  logic [N-1:0]     in_ready_c;

  // Round-robin pick. With ptr one-hot at bit k, higher_mask covers bits
  // k+1..N-1. Requests there win; otherwise wrap to the full request
  // vector, so requester k itself ends up lowest. x & -x isolates the
  // lowest set bit.
  always_comb begin
    higher_mask = ~(ptr_reg | (ptr_reg - LSB));
    req_hi      = bus.in_valid & higher_mask;
    req_src     = (|req_hi) ? req_hi : bus.in_valid;
    pick        = req_src & (~req_src + LSB);
    pick_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_idx = SEL_W'(i);
      end
    end
  end

  // One-hot AND-OR data mux keyed directly off the grant register.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_data_mask
      assign data_masked[gi] = bus.in_data[gi*W +: W] & {W{grant_reg[gi]}};
    end
  endgenerate

  always_comb begin
    data_or = '0;
    for (int i = 0; i < N; i++) begin
      data_or = data_or | data_masked[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= LSB;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    ptr_next    = ptr_reg;
    sel_next    = sel_reg;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    out_data_c  = '0;
    in_ready_c  = '0;
    case (state_reg)
      IDLE: begin
        if (|bus.in_valid) begin
          state_next = LOCK;
          grant_next = pick;
          ptr_next   = pick;
          sel_next   = pick_idx;
        end
      end
      LOCK: begin
        // A dropped valid from the granted requester is just a bubble;
        // the grant stays put until its last beat is accepted.
        out_valid_c = |(bus.in_valid & grant_reg);
        out_last_c  = |(bus.in_last & grant_reg);
        out_data_c  = data_or;
        in_ready_c  = grant_reg & {N{bus.out_ready}};
        if (out_valid_c && bus.out_ready && out_last_c) begin
          state_next = IDLE;
          grant_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_sel   = sel_reg;
  assign bus.busy      = (state_reg == LOCK);

endmodule
